// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle MIPS control unit (master)
// and the datapath that consumes its mux selects and write strobes (slave).
interface multicycle_control_if #(
  parameter int ALUOP_WIDTH = 4
);
  logic [5:0]             OP;
  logic                   mem_ready;
  logic                   PCWrite;
  logic                   PCWriteCond;
  logic                   BranchNE;
  logic [1:0]             PCSource;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic [1:0]             RegDst;
  logic [1:0]             MemtoReg;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [ALUOP_WIDTH-1:0] ALUOp;
  logic [3:0]             state_o;
  logic                   illegal_op;
  logic                   mem_fault;

  modport master (
    input  OP, mem_ready,
    output PCWrite, PCWriteCond, BranchNE, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           state_o, illegal_op, mem_fault
  );

  modport slave (
    output OP, mem_ready,
    input  PCWrite, PCWriteCond, BranchNE, PCSource, IorD, MemRead, MemWrite,
           IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
           state_o, illegal_op, mem_fault
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore multicycle control unit for the MIPS datapath with memory-ready timeout.
// Optional feature: define MULTICYCLE_JAL_EN to give JAL (0x03) its own link write-back state.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    START   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WR  = 4'd5,
    WB_MEM  = 4'd6,
    EXEC_R  = 4'd7,
    WB_R    = 4'd8,
    EXEC_I  = 4'd9,
    WB_I    = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12,
    JAL_WB  = 4'd13,
    ILLEGAL = 4'd14,
    FAULT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD    = ALUOP_WIDTH'(4'b0100);
  localparam logic [ALUOP_WIDTH-1:0] ALU_RTYPE  = ALUOP_WIDTH'(4'b0111);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ORI    = ALUOP_WIDTH'(4'b0101);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ANDI   = ALUOP_WIDTH'(4'b0110);
  localparam logic [ALUOP_WIDTH-1:0] ALU_BRANCH = ALUOP_WIDTH'(4'b0001);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LW     = ALUOP_WIDTH'(4'b0010);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SW     = ALUOP_WIDTH'(4'b0011);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LUI    = ALUOP_WIDTH'(4'b1000);

  // Counter is kept one bit wide when the timeout is disabled so it never collapses to zero width.
  localparam bit                TMO_EN   = (MEM_TIMEOUT > 0);
  localparam int                CNT_W    = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TMO_EN ? MEM_TIMEOUT - 1 : 0);

  state_t           state;
  state_t           nextState;
  logic [5:0]       opQ;
  logic [CNT_W-1:0] waitCnt;
  logic             illegalQ;
  logic             faultQ;
  logic             waitState;
  logic             timeoutHit;

  assign waitState  = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // The MEM_TIMEOUT-th consecutive idle cycle faults; a ready on that same cycle still completes.
  assign timeoutHit = TMO_EN && waitState && !bus.mem_ready && (waitCnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= START;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opQ      <= '0;
      waitCnt  <= '0;
      illegalQ <= 1'b0;
      faultQ   <= 1'b0;
    end else begin
      if (state == DECODE) opQ <= bus.OP;
      if (TMO_EN && waitState && !bus.mem_ready) waitCnt <= waitCnt + CNT_W'(1);
      else                                       waitCnt <= '0;
      if (nextState == ILLEGAL) illegalQ <= 1'b1;
      if (nextState == FAULT)   faultQ   <= 1'b1;
    end
  end

  // NOTE: each combinational block assigns a default first so no path through a case infers a latch.
  always_comb begin
    nextState = state;
    case (state)
      START:   nextState = FETCH;
      FETCH:   if (bus.mem_ready) nextState = DECODE;
               else if (timeoutHit) nextState = FAULT;
      DECODE: begin
        case (bus.OP)
          OP_RTYPE:                        nextState = EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: nextState = EXEC_I;
          OP_LW, OP_SW:                    nextState = MEMADR;
          OP_BEQ, OP_BNE:                  nextState = BRANCH;
          OP_J:                            nextState = JUMP;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:                          nextState = JAL_WB;
`else
          OP_JAL:                          nextState = JUMP;
`endif
          default:                         nextState = ILLEGAL;
        endcase
      end
      MEMADR:  nextState = (opQ == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  if (bus.mem_ready) nextState = WB_MEM;
               else if (timeoutHit) nextState = FAULT;
      MEM_WR:  if (bus.mem_ready) nextState = FETCH;
               else if (timeoutHit) nextState = FAULT;
      EXEC_R:  nextState = WB_R;
      EXEC_I:  nextState = WB_I;
      WB_MEM, WB_R, WB_I, BRANCH, JUMP, JAL_WB, ILLEGAL: nextState = FETCH;
      FAULT:   nextState = FAULT;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNE    = 1'b0;
    bus.PCSource    = 2'b00;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = '0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = ALU_ADD;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ALUOp   = ALU_ADD;
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = (opQ == OP_LW) ? ALU_LW : ALU_SW;
      end
      MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      WB_MEM: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALU_RTYPE;
      end
      WB_R: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (opQ)
          OP_ORI:  bus.ALUOp = ALU_ORI;
          OP_ANDI: bus.ALUOp = ALU_ANDI;
          OP_LUI:  bus.ALUOp = ALU_LUI;
          default: bus.ALUOp = ALU_ADD;
        endcase
      end
      WB_I:    bus.RegWrite = 1'b1;
      BRANCH: begin
        bus.PCWriteCond = 1'b1;
        bus.BranchNE    = (opQ == OP_BNE);
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = ALU_BRANCH;
        bus.PCSource    = 2'b01;
      end
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`ifdef MULTICYCLE_JAL_EN
      JAL_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b10;
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  assign bus.state_o    = state;
  assign bus.illegal_op = illegalQ;
  assign bus.mem_fault  = faultQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: per-instruction expected state paths and control words
// are planned from the opcode rules and compared every cycle against the DUT.
module tb_multicycle_control;

  localparam int TMO = 15;

  localparam int S_START = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEM_RD = 4,
                 S_MEM_WR = 5, S_WB_MEM = 6, S_EXEC_R = 7, S_WB_R = 8, S_EXEC_I = 9,
                 S_WB_I = 10, S_BRANCH = 11, S_JUMP = 12, S_JAL_WB = 13, S_ILLEGAL = 14,
                 S_FAULT = 15;

  // Ready plan value 2 means "don't care": the bench drives a random level.
  localparam int DC = 2;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] PCSource;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_if #(.ALUOP_WIDTH(4)) bus ();

  multicycle_control #(.ALUOP_WIDTH(4), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit expIllegal;
  bit expFault;
  int planState[$];
  int planRdy[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t c;
    c.PCWrite     = bus.PCWrite;
    c.PCWriteCond = bus.PCWriteCond;
    c.BranchNE    = bus.BranchNE;
    c.PCSource    = bus.PCSource;
    c.IorD        = bus.IorD;
    c.MemRead     = bus.MemRead;
    c.MemWrite    = bus.MemWrite;
    c.IRWrite     = bus.IRWrite;
    c.RegDst      = bus.RegDst;
    c.MemtoReg    = bus.MemtoReg;
    c.RegWrite    = bus.RegWrite;
    c.ALUSrcA     = bus.ALUSrcA;
    c.ALUSrcB     = bus.ALUSrcB;
    c.ALUOp       = bus.ALUOp;
    return c;
  endfunction

  // Control word each state must present, straight from the state descriptions.
  function automatic ctl_t expCtl(input int st, input logic [5:0] opc, input logic rdy);
    ctl_t c = '0;
    case (st)
      S_FETCH:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.ALUOp = 4'b0100;
                      c.IRWrite = rdy; c.PCWrite = rdy; end
      S_DECODE: begin c.ALUSrcB = 2'b11; c.ALUOp = 4'b0100; end
      S_MEMADR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
                      c.ALUOp = (opc == 6'h23) ? 4'b0010 : 4'b0011; end
      S_MEM_RD: begin c.MemRead = 1; c.IorD = 1; end
      S_MEM_WR: begin c.MemWrite = 1; c.IorD = 1; end
      S_WB_MEM: begin c.RegWrite = 1; c.MemtoReg = 2'b01; end
      S_EXEC_R: begin c.ALUSrcA = 1; c.ALUOp = 4'b0111; end
      S_WB_R:   begin c.RegWrite = 1; c.RegDst = 2'b01; end
      S_EXEC_I: begin
        c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
        c.ALUOp = (opc == 6'h0d) ? 4'b0101 : (opc == 6'h0c) ? 4'b0110 :
                  (opc == 6'h0f) ? 4'b1000 : 4'b0100;
      end
      S_WB_I:   c.RegWrite = 1;
      S_BRANCH: begin c.PCWriteCond = 1; c.BranchNE = (opc == 6'h05); c.ALUSrcA = 1;
                      c.ALUOp = 4'b0001; c.PCSource = 2'b01; end
      S_JUMP:   begin c.PCWrite = 1; c.PCSource = 2'b10; end
      S_JAL_WB: begin c.RegWrite = 1; c.RegDst = 2'b10; c.MemtoReg = 2'b10;
                      c.PCWrite = 1; c.PCSource = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic checkCycle(input int expState, input logic [5:0] opc, input logic rdy);
    check("state_o", 32'(bus.state_o), 32'(expState));
    check("ctl", 32'(observe()), 32'(expCtl(expState, opc, rdy)));
    check("illegal_op", 32'(bus.illegal_op), 32'(expIllegal));
    check("mem_fault", 32'(bus.mem_fault), 32'(expFault));
  endtask

  function automatic void plan(input int st, input int r);
    planState.push_back(st);
    planRdy.push_back(r);
  endfunction

  // n idle cycles in a wait state; returns 1 when that many idles must time out.
  function automatic bit planWait(input int st, input int n);
    for (int i = 0; i < n && i < TMO; i++) plan(st, 0);
    if (n >= TMO) begin
      for (int i = 0; i < 4; i++) plan(S_FAULT, DC);
      return 1'b1;
    end
    plan(st, 1);
    return 1'b0;
  endfunction

  // Runs one instruction starting in FETCH; cut >= 0 stops after that many cycles.
  task automatic runInstr(input logic [5:0] opc, input int fWait, input int mWait, input int cut);
    int decodeIdx = 1000;
    planState.delete();
    planRdy.delete();
    if (!planWait(S_FETCH, fWait)) begin
      decodeIdx = planState.size();
      plan(S_DECODE, DC);
      case (opc)
        6'h00:                      begin plan(S_EXEC_R, DC); plan(S_WB_R, DC); end
        6'h08, 6'h0d, 6'h0c, 6'h0f: begin plan(S_EXEC_I, DC); plan(S_WB_I, DC); end
        6'h23: begin plan(S_MEMADR, DC); if (!planWait(S_MEM_RD, mWait)) plan(S_WB_MEM, DC); end
        6'h2b: begin plan(S_MEMADR, DC); void'(planWait(S_MEM_WR, mWait)); end
        6'h04, 6'h05:               plan(S_BRANCH, DC);
        6'h02:                      plan(S_JUMP, DC);
`ifdef MULTICYCLE_JAL_EN
        6'h03:                      plan(S_JAL_WB, DC);
`else
        6'h03:                      plan(S_JUMP, DC);
`endif
        default:                    plan(S_ILLEGAL, DC);
      endcase
    end
    for (int i = 0; i < planState.size(); i++) begin
      logic r;
      if (cut >= 0 && i >= cut) break;
      @(negedge clk);
      r = (planRdy[i] == DC) ? 1'($urandom) : (planRdy[i] == 1);
      bus.mem_ready = r;
      bus.OP = (i <= decodeIdx) ? opc : 6'($urandom);
      #1;
      if (planState[i] == S_ILLEGAL) expIllegal = 1'b1;
      if (planState[i] == S_FAULT)   expFault   = 1'b1;
      checkCycle(planState[i], opc, r);
    end
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases it.
  task automatic doReset();
    #2 reset = 1'b1;
    expIllegal = 1'b0;
    expFault   = 1'b0;
    #1 checkCycle(S_START, 6'h00, bus.mem_ready);
    @(negedge clk);
    reset = 1'b0;
    #1 checkCycle(S_START, 6'h00, bus.mem_ready);
  endtask

  logic [5:0] opList[11] = '{6'h00, 6'h08, 6'h0d, 6'h0c, 6'h0f, 6'h23, 6'h2b,
                             6'h04, 6'h05, 6'h02, 6'h03};

  initial begin
    logic [5:0] opc;
    reset = 1'b1;
    bus.OP = 6'h00;
    bus.mem_ready = 1'b0;
    expIllegal = 1'b0;
    expFault = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkCycle(S_START, 6'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkCycle(S_START, 6'h00, 1'b0);

    // Directed instructions from the plan.
    runInstr(6'h00, 0, 0, -1);
    runInstr(6'h23, 0, 3, -1);
    runInstr(6'h05, 0, 0, -1);
    runInstr(6'h04, 1, 0, -1);
    runInstr(6'h2b, 2, 2, -1);
    runInstr(6'h0f, 0, 0, -1);
    runInstr(6'h03, 0, 0, -1);
    runInstr(6'h3f, 0, 0, -1);
    runInstr(6'h00, 0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) opc = 6'($urandom);
      else                           opc = opList[$urandom_range(0, 10)];
      runInstr(opc,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0, -1);
    end

    // One idle cycle short of the timeout completes normally in every wait state.
    runInstr(6'h00, TMO - 1, 0, -1);
    runInstr(6'h23, 0, TMO - 1, -1);
    runInstr(6'h2b, 0, TMO - 1, -1);

    // Reset mid-WB_R and mid-MEM_WR aborts the instruction at once.
    runInstr(6'h00, 0, 0, 4);
    doReset();
    runInstr(6'h2b, 0, 3, 4);
    doReset();

    // Timeouts: FAULT is terminal until reset.
    runInstr(6'h00, TMO, 0, -1);
    doReset();
    runInstr(6'h23, 0, TMO, -1);
    doReset();
    runInstr(6'h2b, 0, TMO, -1);
    doReset();
    runInstr(6'h08, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the stimulus completed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and write-back over 3 to 5+ cycles, instead of decoding the opcode combinationally for a single-cycle datapath. It adds a memory-ready handshake with a timeout, an opcode latch, and illegal-opcode and memory-fault flags. It sits between the instruction register and the datapath muxes, PC and register file.

## Interface
- ALUOP_WIDTH, 4, width of ALUOp; must be ≥4; the 4-bit codes below are zero-extended.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready in a memory state; 0 disables the timeout.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- OP  in  6  opcode field from the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  conditional PC load (branch).
- BranchNE  out  1  with PCWriteCond: 1 = BNE, 0 = BEQ.
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 PC, 1 rs.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- ALUOp  out  ALUOP_WIDTH  ALU operation code.
- state_o  out  4  current state encoding, for debug.
- illegal_op  out  1  sticky: an unknown opcode was decoded.
- mem_fault  out  1  sticky: a memory timeout occurred.

## Operation
- State encoding: START 0, FETCH 1, DECODE 2, MEMADR 3, MEM_RD 4, MEM_WR 5, WB_MEM 6, EXEC_R 7, WB_R 8, EXEC_I 9, WB_I 10, BRANCH 11, JUMP 12, JAL_WB 13, ILLEGAL 14, FAULT 15.
- Outputs are decoded from state (Moore). PCWrite and IRWrite in FETCH are additionally gated by mem_ready. Any output not listed for a state is 0.
- ALUOp codes: add 0100, R-type 0111, ORI 0101, ANDI 0110, branch 0001, LW 0010, SW 0011, LUI 1000.
- START: all outputs 0; next state FETCH.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0100, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=0100.
  - OP is latched into op_q here; every later state decodes op_q only.
  - Next state by opcode: 0x00 → EXEC_R; 0x08/0x0d/0x0c/0x0f → EXEC_I; 0x23/0x2b → MEMADR; 0x04/0x05 → BRANCH; 0x02 → JUMP; 0x03 → see Configuration; any other → ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=0010 (LW) or 0011 (SW); next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1; waits for mem_ready, then WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; waits for mem_ready, then FETCH.
- WB_MEM: RegWrite=1, MemtoReg=01, RegDst=00; next FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=0111; next WB_R.
- WB_R: RegWrite=1, RegDst=01, MemtoReg=00; next FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode; next WB_I.
- WB_I: RegWrite=1, RegDst=00, MemtoReg=00; next FETCH.
- BRANCH:
  - PCWriteCond=1, BranchNE=(op_q==0x05), ALUSrcA=1, ALUSrcB=00, ALUOp=0001, PCSource=01.
  - Next FETCH.
- JUMP: PCWrite=1, PCSource=10; next FETCH.
- ILLEGAL: sets illegal_op; next FETCH (the instruction is skipped).
- Memory timeout counter:
  - Width $clog2(MEM_TIMEOUT+1).
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle those states see mem_ready=0.
  - If the count reaches MEM_TIMEOUT with mem_ready=0, the next state is FAULT and mem_fault is set.
  - mem_ready=1 on the same cycle the count reaches MEM_TIMEOUT wins: the access completes normally.
- FAULT: terminal state; all outputs 0 except mem_fault; leaves only on reset.

## Timing
- Reset (asynchronous):
  - state=START, op_q=0, counter=0, illegal_op=0, mem_fault=0.
  - All control outputs 0 and state_o=0, immediately and for the whole time reset is held.
  - Reset mid-instruction aborts it; no write strobe stays asserted after reset.
- Latency with mem_ready held high:
  - R-type, I-type and LW-less ALU instructions: 4 cycles.
  - LW: 5 cycles. SW: 4 cycles.
  - BEQ, BNE, J: 3 cycles.
- Each cycle of mem_ready low in a wait state adds 1 cycle.
- Changes on OP after DECODE have no effect on the current instruction.

## Configuration
- MULTICYCLE_JAL_EN defined: opcode 0x03 goes DECODE → JAL_WB.
  - JAL_WB: RegWrite=1, RegDst=10, MemtoReg=10, PCWrite=1, PCSource=10; next FETCH.
- MULTICYCLE_JAL_EN undefined: opcode 0x03 is treated exactly as 0x02 (JUMP). State 13 is unreachable, and RegDst[1] and MemtoReg[1] are constant 0.

## Test plan
- Reset asserted mid-WB_R → all outputs 0 and state_o=0 at once; after release, START then FETCH.
- OP=0x00, mem_ready=1 → states 1,2,7,8; RegWrite=1 and RegDst=01 only in WB_R; ALUOp=0111 in EXEC_R.
- OP=0x23, mem_ready low 3 cycles in MEM_RD → states 1,2,3,4,4,4,4,6; IorD=1 throughout MEM_RD; MemtoReg=01 in WB_MEM.
- OP=0x05 → BRANCH with PCWriteCond=1, BranchNE=1, PCSource=01; OP changed to 0x00 during BRANCH → no effect.
- OP=0x3f → ILLEGAL, illegal_op=1 and stays 1, then FETCH; mem_ready low in FETCH for 15 cycles with MEM_TIMEOUT=15 → FAULT, mem_fault=1; only reset exits.
- OP=0x03 with MULTICYCLE_JAL_EN → state 13 with RegDst=10, MemtoReg=10, RegWrite=1; without the macro → state 12, RegWrite=0.
